// File: rtl/fire_ctrl.sv
// Fire request front end: synchronises and debounces the button, then issues
// cooldown- and ammo-limited one-cycle fire pulses with a latched muzzle pose.
// Build option FIRE_CTRL_AUTO_FIRE_EN: a held debounced button re-fires whenever idle.
module fire_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 64,
  parameter int MAX_AMMO        = 8,
  parameter int RELOAD_CYCLES   = 256,
  parameter int TANK_SIZE       = 32,
  parameter int BULLET_SIZE     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_over,
  input  logic       btn_fire,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [1:0] tank_dir,
  output logic       fire,
  output logic [1:0] bullet_direction,
  output logic [9:0] init_x,
  output logic [9:0] init_y,
  output logic [3:0] ammo,
  output logic       ready
);

  // state    | meaning
  // IDLE     | waiting for a legal fire request
  // FIRE     | launch pulse is on fire this cycle
  // COOLDOWN | enforced gap after a shot
  typedef enum logic [1:0] {IDLE, FIRE, COOLDOWN} state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam int RL_W = $clog2(RELOAD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [RL_W-1:0] RL_LAST  = RL_W'(RELOAD_CYCLES - 1);
  localparam logic [3:0]      AMMO_MAX = 4'(MAX_AMMO);
  localparam logic [9:0]      OFS      = 10'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [9:0]      BS       = 10'(BULLET_SIZE);
  localparam logic [10:0]     TS       = 11'(TANK_SIZE);

  state_t            state, state_nxt;
  logic [1:0]        sync_q;
  logic              sync, deb, deb_d;
  logic [DB_W-1:0]   db_cnt;
  logic [CD_W-1:0]   cd_cnt;
  logic [RL_W-1:0]   rl_cnt;
  logic              trig, shot, reload_tick;

  assign sync = sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      deb    <= 1'b0;
      deb_d  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_fire};
      deb_d  <= deb;
      if (sync != deb) begin
        if (db_cnt == DB_LAST) begin
          deb    <= sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef FIRE_CTRL_AUTO_FIRE_EN
  // Armed drops during game_over so a button held across it must be released first.
  logic armed;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         armed <= 1'b0;
    else if (game_over) armed <= 1'b0;
    else if (!deb)      armed <= 1'b1;
  end
  assign trig = deb & armed & (deb_d | armed);
`else
  assign trig = deb & ~deb_d;
`endif

  always_comb begin
    state_nxt = state;
    shot      = 1'b0;
    case (state)
      IDLE: begin
        if (trig && ammo != 4'd0 && !game_over) begin
          state_nxt = FIRE;
          shot      = 1'b1;
        end
      end
      FIRE:     state_nxt = COOLDOWN;
      COOLDOWN: if (cd_cnt == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (game_over) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cd_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (game_over)                         cd_cnt <= '0;
      else if (state == FIRE)                cd_cnt <= CD_LOAD;
      else if (state == COOLDOWN && cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;
    end
  end

  logic [9:0]  x_ofs, y_ofs, x_left, y_up, mx, my;
  logic [10:0] x_far, y_far;

  always_comb begin
    x_ofs  = tank_x + OFS;
    y_ofs  = tank_y + OFS;
    x_left = (tank_x < BS) ? 10'd0 : tank_x - BS;
    y_up   = (tank_y < BS) ? 10'd0 : tank_y - BS;
    x_far  = {1'b0, tank_x} + TS;
    y_far  = {1'b0, tank_y} + TS;
    mx     = x_ofs;
    my     = y_up;
    case (tank_dir)
      2'b00: begin mx = x_ofs; my = y_up; end
      2'b01: begin mx = x_ofs; my = y_far[10] ? 10'h3FF : y_far[9:0]; end
      2'b10: begin mx = x_left; my = y_ofs; end
      2'b11: begin mx = x_far[10] ? 10'h3FF : x_far[9:0]; my = y_ofs; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire             <= 1'b0;
      bullet_direction <= 2'b00;
      init_x           <= '0;
      init_y           <= '0;
    end else begin
      fire <= shot;
      if (shot) begin
        bullet_direction <= tank_dir;
        init_x           <= mx;
        init_y           <= my;
      end
    end
  end

  // A shot can only happen with ammo != 0 and a reload only below MAX_AMMO,
  // so the counter cannot wrap in either direction.
  assign reload_tick = !game_over && (ammo < AMMO_MAX) && (rl_cnt == RL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ammo   <= AMMO_MAX;
      rl_cnt <= '0;
    end else begin
      if (!game_over) begin
        if (ammo < AMMO_MAX && rl_cnt != RL_LAST) rl_cnt <= rl_cnt + 1'b1;
        else                                      rl_cnt <= '0;
      end
      case ({shot, reload_tick})
        2'b10:   ammo <= ammo - 1'b1;
        2'b01:   ammo <= ammo + 1'b1;
        default: ammo <= ammo;
      endcase
    end
  end

  assign ready = (state == IDLE) && (ammo != 4'd0) && !game_over;

endmodule
